// File: rtl/lcd_write_sched.sv
// Character-LCD bus sequencer: runs the HD44780 4-bit init/config after reset, then
// round-robin arbitrates two byte-write requesters and strobes each byte as two nibbles.
module lcd_write_sched #(
  parameter int unsigned T_PWRUP  = 750000,
  parameter int unsigned T_SETUP  = 2,
  parameter int unsigned T_EHIGH  = 12,
  parameter int unsigned T_HOLD   = 1,
  parameter int unsigned T_NIBGAP = 50,
  parameter int unsigned T_BYTE   = 2000,
  parameter int unsigned T_CLEAR  = 82000,
  parameter int unsigned T_INIT1  = 205000,
  parameter int unsigned T_INIT2  = 5000,
  parameter int unsigned T_INIT3  = 2000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ0,
  input  logic        RS0,
  input  logic [7:0]  DIN0,
  output logic        GNT0,
  input  logic        REQ1,
  input  logic        RS1,
  input  logic [7:0]  DIN1,
  output logic        GNT1,
  output logic        READY,
  output logic [11:8] SF_D,
  output logic        LCD_E,
  output logic        LCD_RS,
  output logic        LCD_RW
);

  typedef enum logic [2:0] {
    S_PWR_WAIT, S_GAP, S_SETUP, S_EHIGH, S_HOLD, S_WAIT, S_IDLE
  } state_t;

  typedef enum logic [1:0] {M_INIT, M_CFG, M_USER} mode_t;

  state_t      state;
  mode_t       mode;
  logic [31:0] cnt;
  logic [31:0] wait_len;
  logic [1:0]  idx;
  logic        nib_lo;
  logic        cur_rs;
  logic [7:0]  cur_byte;
  logic        rr_ptr;

  logic [3:0]  next_nib;
  logic        next_rs;
  logic [31:0] hold_wait;
  logic        grant0;
  logic        grant1;

  function automatic logic [7:0] cfg_byte(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h28;
      2'd1:    return 8'h06;
      2'd2:    return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

  // Nibble and RS presented at the start of the next strobe
  always_comb begin
    next_nib = nib_lo ? cur_byte[3:0] : cur_byte[7:4];
    next_rs  = cur_rs;
    if (mode == M_INIT) begin
      next_nib = (idx == 2'd3) ? 4'h2 : 4'h3;
      next_rs  = 1'b0;
    end
  end

  // Wait that follows the strobe just completed
  always_comb begin
    hold_wait = 32'(T_BYTE);
    if (mode == M_INIT) begin
      case (idx)
        2'd0:    hold_wait = 32'(T_INIT1);
        2'd1:    hold_wait = 32'(T_INIT2);
        default: hold_wait = 32'(T_INIT3);
      endcase
    end else if (!nib_lo) begin
      hold_wait = 32'(T_NIBGAP);
    end else if (!cur_rs && (cur_byte == 8'h01 || cur_byte == 8'h02)) begin
      hold_wait = 32'(T_CLEAR);
    end
  end

  // Ties go to the requester not granted last
  assign grant0 = REQ0 && (!REQ1 || !rr_ptr);
  assign grant1 = REQ1 && !grant0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_PWR_WAIT;
      mode     <= M_INIT;
      cnt      <= '0;
      wait_len <= '0;
      idx      <= '0;
      nib_lo   <= 1'b0;
      cur_rs   <= 1'b0;
      cur_byte <= '0;
      rr_ptr   <= 1'b0;
      GNT0     <= 1'b0;
      GNT1     <= 1'b0;
      READY    <= 1'b0;
      SF_D     <= '0;
      LCD_E    <= 1'b0;
      LCD_RS   <= 1'b0;
      LCD_RW   <= 1'b0;
    end else begin
      GNT0   <= 1'b0;
      GNT1   <= 1'b0;
      LCD_RW <= 1'b0;
      case (state)
        S_PWR_WAIT: begin
          if (cnt == 32'(T_PWRUP - 1)) begin
            cnt   <= '0;
            state <= S_GAP;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_GAP: begin
          cnt    <= '0;
          SF_D   <= next_nib;
          LCD_RS <= next_rs;
          state  <= S_SETUP;
        end
        S_SETUP: begin
          if (cnt == 32'(T_SETUP - 1)) begin
            cnt   <= '0;
            LCD_E <= 1'b1;
            state <= S_EHIGH;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_EHIGH: begin
          if (cnt == 32'(T_EHIGH - 1)) begin
            cnt   <= '0;
            LCD_E <= 1'b0;
            state <= S_HOLD;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_HOLD: begin
          if (cnt == 32'(T_HOLD - 1)) begin
            cnt      <= '0;
            wait_len <= hold_wait;
            state    <= S_WAIT;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_WAIT: begin
          if (cnt == wait_len - 32'd1) begin
            cnt <= '0;
            if (mode == M_INIT) begin
              state <= S_GAP;
              if (idx == 2'd3) begin
                mode     <= M_CFG;
                idx      <= '0;
                nib_lo   <= 1'b0;
                cur_rs   <= 1'b0;
                cur_byte <= cfg_byte(2'd0);
              end else begin
                idx <= idx + 2'd1;
              end
            end else if (!nib_lo) begin
              nib_lo <= 1'b1;
              state  <= S_GAP;
            end else if (mode == M_CFG && idx != 2'd3) begin
              idx      <= idx + 2'd1;
              cur_byte <= cfg_byte(idx + 2'd1);
              nib_lo   <= 1'b0;
              state    <= S_GAP;
            end else begin
              mode  <= M_USER;
              READY <= 1'b1;
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_IDLE: begin
          if (grant0 || grant1) begin
            cur_byte <= grant0 ? DIN0 : DIN1;
            cur_rs   <= grant0 ? RS0 : RS1;
            SF_D     <= grant0 ? DIN0[7:4] : DIN1[7:4];
            LCD_RS   <= grant0 ? RS0 : RS1;
            GNT0     <= grant0;
            GNT1     <= grant1;
            rr_ptr   <= grant0;
            READY    <= 1'b0;
            nib_lo   <= 1'b0;
            cnt      <= '0;
            state    <= S_SETUP;
          end
        end
        default: state <= S_PWR_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_sched.sv
// Directed bench for lcd_write_sched with shortened timing; each scenario task checks inline.
module tb_lcd_write_sched;

  logic        CLK = 1'b0;
  logic        RST, REQ0, RS0, REQ1, RS1;
  logic [7:0]  DIN0, DIN1;
  logic        GNT0, GNT1, READY, LCD_E, LCD_RS, LCD_RW;
  logic [11:8] SF_D;

  int vectors = 0;
  int fails = 0;

  lcd_write_sched #(
    .T_PWRUP(20), .T_SETUP(2), .T_EHIGH(3), .T_HOLD(1), .T_NIBGAP(4),
    .T_BYTE(6), .T_CLEAR(10), .T_INIT1(7), .T_INIT2(6), .T_INIT3(5)
  ) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .RS0(RS0), .DIN0(DIN0), .GNT0(GNT0),
    .REQ1(REQ1), .RS1(RS1), .DIN1(DIN1), .GNT1(GNT1),
    .READY(READY), .SF_D(SF_D), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW)
  );

  always #5 CLK = ~CLK;

  // Bus monitor: logs E pulses (start cycle, {RS,nibble}, width) and protocol slips
  int         cyc = 0;
  int         cyc_rel = 0;
  int         rise_cyc[$];
  logic [4:0] rise_val[$];
  int         wid[$];
  int         last_rise = 0;
  int         stable_bad = 0;
  int         overlap = 0;
  logic       e_prev = 1'b0;
  logic [3:0] sfd_prev = 4'h0;
  logic       rs_prev = 1'b0;

  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (LCD_E && !e_prev) begin
      if (SF_D !== sfd_prev || LCD_RS !== rs_prev) stable_bad = stable_bad + 1;
      rise_cyc.push_back(cyc);
      rise_val.push_back({LCD_RS, SF_D});
      last_rise = cyc;
    end else if (LCD_E && e_prev) begin
      if (SF_D !== sfd_prev || LCD_RS !== rs_prev) stable_bad = stable_bad + 1;
    end else if (!LCD_E && e_prev && !RST) begin
      wid.push_back(cyc - last_rise);
    end
    if (GNT0 && GNT1) overlap = overlap + 1;
    e_prev   = LCD_E;
    sfd_prev = SF_D;
    rs_prev  = LCD_RS;
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic clear_log();
    rise_cyc.delete();
    rise_val.delete();
    wid.delete();
  endtask

  task automatic wait_ready(output int rc, input int budget);
    rc = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (READY === 1'b1) begin
        rc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0; RS0 = 1'b0; RS1 = 1'b0;
    DIN0 = 8'h00; DIN1 = 8'h00;
    repeat (3) tick();
    vectors++;
    if ({SF_D, LCD_E, LCD_RS, LCD_RW, GNT0, GNT1, READY} !== 10'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b want %b",
               {SF_D, LCD_E, LCD_RS, LCD_RW, GNT0, GNT1, READY}, 10'b0);
    end
    RST = 1'b0;
    cyc_rel = cyc;
    clear_log();
    repeat (5) tick();
    vectors++;
    if (READY !== 1'b0 || LCD_E !== 1'b0) begin
      fails++;
      $display("FAIL pwrup_quiet: got READY=%b E=%b want 0 0", READY, LCD_E);
    end
  endtask

  task automatic test_init();
    logic [3:0] exp_nib [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6,
                                 4'h0, 4'hC, 4'h0, 4'h1};
    int exp_d [11] = '{14, 13, 12, 12, 11, 13, 11, 13, 11, 13, 11};
    int rc;
    wait_ready(rc, 3000);
    vectors++;
    if (rc < 0) begin
      fails++;
      $display("FAIL init_ready_timeout: got no READY want READY within 3000 cycles");
      return;
    end
    vectors++;
    if (rise_cyc.size() != 12) begin
      fails++;
      $display("FAIL init_pulse_count: got %0d want 12", rise_cyc.size());
      return;
    end
    vectors++;
    if (rise_cyc[0] - cyc_rel != 23) begin
      fails++;
      $display("FAIL init_first_pulse: got %0d want 23", rise_cyc[0] - cyc_rel);
    end
    for (int i = 0; i < 12; i++) begin
      vectors++;
      if (rise_val[i] !== {1'b0, exp_nib[i]}) begin
        fails++;
        $display("FAIL init_nibble[%0d]: got %h want %h", i, rise_val[i], {1'b0, exp_nib[i]});
      end
    end
    for (int i = 0; i < 11; i++) begin
      vectors++;
      if (rise_cyc[i+1] - rise_cyc[i] != exp_d[i]) begin
        fails++;
        $display("FAIL init_spacing[%0d]: got %0d want %0d", i, rise_cyc[i+1] - rise_cyc[i], exp_d[i]);
      end
    end
    vectors++;
    if (rc - rise_cyc[11] != 14) begin
      fails++;
      $display("FAIL init_clear_wait: got %0d want 14", rc - rise_cyc[11]);
    end
  endtask

  task automatic test_single();
    int rc, g;
    clear_log();
    REQ0 = 1'b1; RS0 = 1'b1; DIN0 = 8'h41;
    tick();
    g = cyc;
    vectors++;
    if ({GNT0, GNT1, READY} !== 3'b100) begin
      fails++;
      $display("FAIL single_grant: got GNT0,GNT1,READY=%b want 100", {GNT0, GNT1, READY});
    end
    REQ0 = 1'b0;
    tick();
    vectors++;
    if (GNT0 !== 1'b0 || READY !== 1'b0) begin
      fails++;
      $display("FAIL single_gnt_width: got GNT0=%b READY=%b want 0 0", GNT0, READY);
    end
    wait_ready(rc, 200);
    vectors++;
    if (rc < 0 || rise_cyc.size() != 2) begin
      fails++;
      $display("FAIL single_pulses: got %0d pulses rc=%0d want 2 and READY", rise_cyc.size(), rc);
      return;
    end
    vectors++;
    if ({rise_val[0], rise_val[1]} !== {5'h14, 5'h11}) begin
      fails++;
      $display("FAIL single_nibbles: got %h %h want 14 11", rise_val[0], rise_val[1]);
    end
    vectors++;
    if (rise_cyc[0] - g != 2 || rise_cyc[1] - rise_cyc[0] != 11 || rc - rise_cyc[1] != 10) begin
      fails++;
      $display("FAIL single_timing: got %0d %0d %0d want 2 11 10",
               rise_cyc[0] - g, rise_cyc[1] - rise_cyc[0], rc - rise_cyc[1]);
    end
  endtask

  task automatic test_post_wait(input logic rs, input logic [7:0] d, input int exp_w);
    int rc;
    clear_log();
    REQ1 = 1'b1; RS1 = rs; DIN1 = d;
    tick();
    vectors++;
    if ({GNT0, GNT1} !== 2'b01) begin
      fails++;
      $display("FAIL post_grant_%h: got GNT0,GNT1=%b want 01", d, {GNT0, GNT1});
    end
    REQ1 = 1'b0;
    wait_ready(rc, 200);
    vectors++;
    if (rc < 0 || rise_cyc.size() != 2) begin
      fails++;
      $display("FAIL post_pulses_%h: got %0d pulses rc=%0d want 2 and READY", d, rise_cyc.size(), rc);
      return;
    end
    vectors++;
    if ({rise_val[0], rise_val[1]} !== {rs, d[7:4], rs, d[3:0]}) begin
      fails++;
      $display("FAIL post_nibbles_%h: got %h %h want %h %h", d, rise_val[0], rise_val[1],
               {rs, d[7:4]}, {rs, d[3:0]});
    end
    vectors++;
    if (rc - rise_cyc[1] != exp_w) begin
      fails++;
      $display("FAIL post_wait_%h_rs%b: got %0d want %0d", d, rs, rc - rise_cyc[1], exp_w);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_v [8] = '{5'h14, 5'h1F, 5'h13, 5'h1A, 5'h14, 5'h1F, 5'h13, 5'h1A};
    int gid [4];
    int gcyc [4];
    int ng = 0;
    int rc;
    clear_log();
    REQ0 = 1'b1; RS0 = 1'b1; DIN0 = 8'h4F;
    REQ1 = 1'b1; RS1 = 1'b1; DIN1 = 8'h3A;
    for (int b = 0; b < 400 && ng < 4; b++) begin
      tick();
      if (GNT0 || GNT1) begin
        gid[ng] = GNT1 ? 1 : 0;
        gcyc[ng] = cyc;
        ng++;
        if (ng == 4) begin
          REQ0 = 1'b0; REQ1 = 1'b0;
        end
      end
    end
    vectors++;
    if (ng != 4) begin
      fails++;
      $display("FAIL b2b_grant_count: got %0d want 4", ng);
      REQ0 = 1'b0; REQ1 = 1'b0;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (gid[i] != i % 2) begin
        fails++;
        $display("FAIL b2b_order[%0d]: got %0d want %0d", i, gid[i], i % 2);
      end
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (gcyc[i+1] - gcyc[i] != 24) begin
        fails++;
        $display("FAIL b2b_spacing[%0d]: got %0d want 24", i, gcyc[i+1] - gcyc[i]);
      end
    end
    wait_ready(rc, 200);
    vectors++;
    if (rc < 0 || rise_cyc.size() != 8) begin
      fails++;
      $display("FAIL b2b_pulses: got %0d pulses rc=%0d want 8 and READY", rise_cyc.size(), rc);
      return;
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (rise_val[i] !== exp_v[i]) begin
        fails++;
        $display("FAIL b2b_nibble[%0d]: got %h want %h", i, rise_val[i], exp_v[i]);
      end
    end
  endtask

  task automatic test_req_during_init();
    int early = 0;
    int rc = -1;
    RST = 1'b1;
    repeat (2) tick();
    RST = 1'b0;
    cyc_rel = cyc;
    clear_log();
    REQ0 = 1'b1; RS0 = 1'b1; DIN0 = 8'h5A;
    for (int b = 0; b < 3000; b++) begin
      tick();
      if (READY === 1'b1) begin
        rc = cyc;
        break;
      end
      if (GNT0 || GNT1) early++;
    end
    vectors++;
    if (rc < 0 || early != 0) begin
      fails++;
      $display("FAIL init_req_early: got %0d early grants rc=%0d want 0 and READY", early, rc);
      REQ0 = 1'b0;
      return;
    end
    tick();
    vectors++;
    if ({GNT0, GNT1, READY} !== 3'b100) begin
      fails++;
      $display("FAIL init_req_grant: got GNT0,GNT1,READY=%b want 100", {GNT0, GNT1, READY});
    end
    REQ0 = 1'b0;
    wait_ready(rc, 200);
    vectors++;
    if (rc < 0 || rise_cyc.size() != 14) begin
      fails++;
      $display("FAIL init_req_pulses: got %0d pulses rc=%0d want 14 and READY", rise_cyc.size(), rc);
      return;
    end
    vectors++;
    if ({rise_val[12], rise_val[13]} !== {5'h15, 5'h1A} || rc - rise_cyc[13] != 10) begin
      fails++;
      $display("FAIL init_req_xfer: got %h %h wait %0d want 15 1a wait 10",
               rise_val[12], rise_val[13], rc - rise_cyc[13]);
    end
  endtask

  task automatic test_rst_mid();
    int rc;
    logic seen = 1'b0;
    REQ0 = 1'b1; RS0 = 1'b1; DIN0 = 8'h77;
    for (int b = 0; b < 50 && !seen; b++) begin
      tick();
      if (GNT0) REQ0 = 1'b0;
      if (LCD_E === 1'b1) seen = 1'b1;
    end
    REQ0 = 1'b0;
    vectors++;
    if (!seen) begin
      fails++;
      $display("FAIL rst_mid_no_strobe: got E=0 want E=1 within 50 cycles");
    end
    #2 RST = 1'b1;
    #1;
    vectors++;
    if ({SF_D, LCD_E, LCD_RS, LCD_RW, GNT0, GNT1, READY} !== 10'b0) begin
      fails++;
      $display("FAIL rst_mid_async: got %b want %b",
               {SF_D, LCD_E, LCD_RS, LCD_RW, GNT0, GNT1, READY}, 10'b0);
    end
    repeat (2) tick();
    RST = 1'b0;
    cyc_rel = cyc;
    clear_log();
    wait_ready(rc, 3000);
    vectors++;
    if (rc < 0 || rise_cyc.size() != 12) begin
      fails++;
      $display("FAIL rst_mid_reinit: got %0d pulses rc=%0d want 12 and READY", rise_cyc.size(), rc);
      return;
    end
    vectors++;
    if (rise_cyc[0] - cyc_rel != 23 || rise_val[0] !== 5'h03 || rise_val[11] !== 5'h01) begin
      fails++;
      $display("FAIL rst_mid_restart: got offset %0d first %h last %h want 23 03 01",
               rise_cyc[0] - cyc_rel, rise_val[0], rise_val[11]);
    end
  endtask

  task automatic test_bus_rules();
    vectors++;
    if (overlap != 0) begin
      fails++;
      $display("FAIL gnt_overlap: got %0d cycles want 0", overlap);
    end
    vectors++;
    if (stable_bad != 0) begin
      fails++;
      $display("FAIL data_stable: got %0d slips want 0", stable_bad);
    end
    foreach (wid[i]) begin
      vectors++;
      if (wid[i] != 3) begin
        fails++;
        $display("FAIL e_width[%0d]: got %0d want 3", i, wid[i]);
      end
    end
    vectors++;
    if (LCD_RW !== 1'b0) begin
      fails++;
      $display("FAIL lcd_rw: got %b want 0", LCD_RW);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_single();
    test_post_wait(1'b0, 8'h01, 14);
    test_post_wait(1'b0, 8'h02, 14);
    test_post_wait(1'b1, 8'h01, 10);
    test_back_to_back();
    test_req_during_init();
    test_rst_mid();
    test_bus_rules();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/lcd_write_sched.md
Name: lcd_write_sched

Overview:
- Sequencer and arbiter for the shared 4-bit character-LCD bus (SF_D[11:8], LCD_E, LCD_RS, LCD_RW).
- After reset it runs the HD44780 4-bit power-on init and configuration sequence by itself.
- It then shares the bus between two byte-write requesters (e.g. arithmetic-result display and status display) using round-robin arbitration.
- It performs each byte as two timed nibble strobes.

Parameters:
- T_PWRUP, 750000: cycles of idle wait after reset before the first init nibble (15 ms at 50 MHz).
- T_SETUP, 2: cycles data/RS are stable with E low before the E pulse.
- T_EHIGH, 12: cycles LCD_E is held high per nibble.
- T_HOLD, 1: cycles data/RS are held after E falls.
- T_NIBGAP, 50: wait cycles between the upper and lower nibble (1 us).
- T_BYTE, 2000: wait cycles after a byte completes (40 us).
- T_CLEAR, 82000: wait cycles after the clear (0x01) or home (0x02) command (1.64 ms).
- T_INIT1, 205000 / T_INIT2, 5000 / T_INIT3, 2000: waits after init nibbles 1, 2 and 3/4.

Ports:
- CLK  in  1  system clock (50 MHz)
- RST  in  1  asynchronous, active-high reset
- REQ0  in  1  requester 0 write request
- RS0  in  1  requester 0 register select (0 = command, 1 = data)
- DIN0  in  8  requester 0 byte
- GNT0  out  1  one-cycle accept pulse for requester 0
- REQ1, RS1, DIN1, GNT1: same as above, for requester 1
- READY  out  1  high only in IDLE (init/config done, bus free)
- SF_D  out  4 [11:8]  LCD data nibble
- LCD_E  out  1  LCD enable strobe
- LCD_RS  out  1  LCD register select
- LCD_RW  out  1  constant 0 (write only)

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous, active-high. All outputs and state are registered.
- Reset values:
  - SF_D=0, LCD_E=0, LCD_RS=0, LCD_RW=0.
  - GNT0=GNT1=0, READY=0.
  - Round-robin pointer = requester 0 favoured. State = PWR_WAIT, wait counter cleared.
- RST mid-transfer: LCD_E drops immediately (asynchronously). The full init sequence reruns; any latched byte is discarded.
- Nibble strobe (used everywhere), for a given nibble N and RS value:
  - T_SETUP cycles with SF_D=N, LCD_RS=RS, LCD_E=0.
  - T_EHIGH cycles with LCD_E=1.
  - T_HOLD cycles with LCD_E=0, SF_D and LCD_RS unchanged.
  - LCD_E is never high outside this window.
- State sequence:
  - PWR_WAIT: T_PWRUP cycles.
  - INIT: nibbles 0x3, 0x3, 0x3, 0x2 with RS=0, followed by waits T_INIT1, T_INIT2, T_INIT3, T_INIT3 respectively.
  - CFG: bytes 0x28, 0x06, 0x0C, 0x01 with RS=0, each sent as a full byte transfer. The last one uses the T_CLEAR wait.
  - IDLE.
- Byte transfer:
  - Upper nibble strobe, then T_NIBGAP wait.
  - Lower nibble strobe, then a post-byte wait: T_CLEAR if RS=0 and byte is 0x01 or 0x02, else T_BYTE.
  - Then return to IDLE.
- READY is 1 only in IDLE; it goes 0 on the cycle after a grant.
- Arbitration, on each IDLE cycle:
  - If exactly one REQx is high, that requester wins.
  - If both are high, the requester not granted last wins; after reset, requester 0 wins.
  - On the winning edge, RSx/DINx are latched, GNTx=1 for exactly one cycle (the first cycle of the transfer), and the pointer is updated.
  - GNT0 and GNT1 are never high together.
- Requester rules:
  - Hold REQx, RSx and DINx stable until GNTx is seen.
  - Deassert REQx in the GNT cycle, or hold it to request another byte.
  - REQx still high on the next IDLE is a new request.
  - A request asserted during init/config or a transfer waits; nothing is dropped or errored.
- Every wait counter reloads on entry to its state. A 1-cycle gap exists between waits and the next strobe's setup (counted in the state transition, fixed and deterministic).
- Back-to-back REQ0 and REQ1 both held: grants alternate 0,1,0,1.

Test Plan (run with all T_* = small values, e.g. T_PWRUP=20, T_EHIGH=3, T_NIBGAP=4, T_BYTE=6, T_CLEAR=10, T_INIT*=5):
- Reset then idle -> exactly 4 single E pulses with SF_D 3,3,3,2 and RS=0; then 8 pulses giving nibbles 2,8,0,6,0,C,0,1; then READY=1 after the T_CLEAR wait.
- REQ0=1, RS0=1, DIN0=0x41 in IDLE -> GNT0 one cycle, READY=0, pulses SF_D=4 then 1 with LCD_RS=1 and T_NIBGAP between them, READY back after T_BYTE.
- REQ0 and REQ1 rise on the same cycle and both are held -> grants in order 0,1,0,1; GNT0 and GNT1 never overlap; LCD shows the alternating bytes.
- REQ1 with RS1=0, DIN1=0x01 -> post-byte wait equals T_CLEAR, not T_BYTE; the same check applies for 0x02.
- REQ0 asserted during INIT -> no GNT0 until READY; then a single grant and a correct transfer.
- RST pulsed while LCD_E=1 mid-byte -> LCD_E=0 with no clock edge; outputs return to reset values; the init sequence restarts from PWR_WAIT.
